dtc_slave_top: RTL and testbench

Behavioural/synthesizable model of one front-end electronics (FEE) card's DTC (Data-Trigger-Control) link endpoint, as seen from the SRU. It decodes serial trigger and register-access frames arriving on `dtc_trig`, emits active-low L0/L1 strobes, answers register accesses on `dtc_return`, and ships a fixed-format event frame on `dtc_data` for every accepted L1. Forty instances make up the SRU simulation FEE crate.

---
 rtl/dtc_slave_pkg.sv | 73 +++++++
 rtl/dtc_ser_tx.sv | 37 +++
 rtl/dtc_slave_top.sv | 220 ++++++++++++++++++++++
 tb/tb_dtc_slave_top.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dtc_slave_pkg.sv
// Shared constants, FSM state type and uplink frame builders for the DTC slave endpoint.
// Defining DTC_SLAVE_PARITY_EN appends one even-parity bit to every reply and event frame.
package dtc_slave_pkg;

`ifdef DTC_SLAVE_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    localparam logic [1:0] TYPE_L0 = 2'b00;
    localparam logic [1:0] TYPE_L1 = 2'b01;
    localparam logic [1:0] TYPE_WR = 2'b10;
    localparam logic [1:0] TYPE_RD = 2'b11;

    localparam logic [7:0] ADDR_VERSION = 8'h00;
    localparam logic [7:0] ADDR_CTRL    = 8'h01;
    localparam logic [7:0] ADDR_L0CNT   = 8'h02;
    localparam logic [7:0] ADDR_L1CNT   = 8'h03;
    localparam logic [7:0] ADDR_SCRATCH = 8'h04;
    localparam logic [7:0] ADDR_STATUS  = 8'h05;
    localparam logic [7:0] ADDR_DROPCNT = 8'h06;

    localparam logic [3:0] HDR_NIBBLE = 4'hA;

    localparam int WORD_LEN     = 16;
    localparam int EVT_WORDS_HI = 8;
    localparam int EVT_WORDS_LO = 4;
    // Frame lengths exclude the start bit.
    localparam int REPLY_LEN    = 1 + WORD_LEN + PAR_BITS;
    localparam int BODY_LEN     = WORD_LEN * (1 + EVT_WORDS_HI);
    localparam int EVT_LEN      = BODY_LEN + PAR_BITS;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TYPE,
        ST_ADDR,
        ST_DATA,
        ST_EXEC
    } dec_state_t;

    function automatic logic [REPLY_LEN-1:0] build_reply(input logic err, input logic [15:0] dat);
        logic [REPLY_LEN-1:0] f;
`ifdef DTC_SLAVE_PARITY_EN
        f = {err, dat, ^{err, dat}};
`else
        f = {err, dat};
`endif
        return f;
    endfunction

    // Left-aligned so the shifter can stop early for the short (LGSEN=0) frame.
    function automatic logic [EVT_LEN-1:0] build_event(input logic [11:0] evcnt, input logic lg);
        logic [BODY_LEN-1:0] body;
        logic [EVT_LEN-1:0]  f;
        int                  nw;
        nw   = lg ? EVT_WORDS_HI : EVT_WORDS_LO;
        body = '0;
        body[BODY_LEN-1 -: WORD_LEN] = {HDR_NIBBLE, evcnt};
        for (int k = 0; k < EVT_WORDS_HI; k++) begin
            if (k < nw)
                body[BODY_LEN-1-WORD_LEN*(k+1) -: WORD_LEN] = {evcnt[7:0], 8'(k)};
        end
`ifdef DTC_SLAVE_PARITY_EN
        f = {body, 1'b0};
        f[EVT_LEN-1-WORD_LEN*(1+nw)] = ^body;
`else
        f = body;
`endif
        return f;
    endfunction

endpackage

// File: rtl/dtc_ser_tx.sv
// Generic start-bit + len-bit MSB-first serializer; data is left-aligned in a W-bit word.
// ready is high during the final bit so a following frame can go out back to back.
module dtc_ser_tx #(
    parameter int W  = 17,
    parameter int CW = $clog2(W + 2)
) (
    input  logic          clk_sys,
    input  logic          rst,
    input  logic          load,
    input  logic [W-1:0]  data,
    input  logic [CW-1:0] len,
    output logic          ser,
    output logic          busy,
    output logic          ready
);

    logic [W:0]    sreg;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (load && ready) begin
            sreg <= {1'b1, data};
            cnt  <= len + 1'b1;
        end else if (cnt != '0) begin
            sreg <= {sreg[W-1:0], 1'b0};
            cnt  <= cnt - 1'b1;
        end
    end

    assign ser   = sreg[W];
    assign busy  = (cnt != '0);
    assign ready = (cnt <= CW'(1));

endmodule

// File: rtl/dtc_slave_top.sv
// DTC link endpoint of one FEE card: downlink decoder, register file, L0/L1 strobes, reply and event uplinks.
// Build option DTC_SLAVE_PARITY_EN (handled in dtc_slave_pkg) adds an even-parity bit to both uplinks.
//   state | meaning
//   IDLE  | wait for start bit
//   TYPE  | shift 2 type bits; L0/L1 fire on the second
//   ADDR  | shift 8 address bits
//   DATA  | shift 16 write-data bits
//   EXEC  | perform access and launch reply
module dtc_slave_top
    import dtc_slave_pkg::*;
#(
    parameter bit        LGSEN_Init = 1'b1,
    parameter bit [15:0] FEEFMVer   = 16'h5043
) (
    input  logic rdoclk,
    input  logic reset,
    input  logic dtc_clk,
    input  logic dtc_trig,
    output logic dtc_data,
    output logic dtc_return,
    output logic trig_l0n,
    output logic trig_l1n,
    input  logic fee_flag
);

    localparam int R_CW = $clog2(REPLY_LEN + 2);
    localparam int E_CW = $clog2(EVT_LEN + 2);
    localparam logic [E_CW-1:0] EVT_BITS_HI = E_CW'(WORD_LEN * (1 + EVT_WORDS_HI) + PAR_BITS);
    localparam logic [E_CW-1:0] EVT_BITS_LO = E_CW'(WORD_LEN * (1 + EVT_WORDS_LO) + PAR_BITS);

    dec_state_t state, state_nxt;
    logic [3:0]  bit_cnt;
    logic [1:0]  type_sr;
    logic [7:0]  addr_sr;
    logic [15:0] data_sr;
    logic        l0_hit, l1_hit, exec;

    logic [15:0] ctrl, scratch, l0cnt, l1cnt, dropcnt;
    logic        l1_sup;
    logic [15:0] rd_val, rep_dat;
    logic        addr_ok, addr_ro, rep_err, is_write, exec_ok;
    logic        r_busy, unused_r_ready, unused_dtc_clk;
    logic [REPLY_LEN-1:0] r_frame;

    logic        pend_vld, pend_lg, launch_pend, l1_acc, d_load, d_lg, d_busy, d_ready;
    logic [11:0] pend_ev, evcnt_new;
    logic [EVT_LEN-1:0] d_frame;
    logic [E_CW-1:0]    d_len;

    assign unused_dtc_clk = dtc_clk;

    always_ff @(posedge rdoclk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (dtc_trig) state_nxt = ST_TYPE;
            ST_TYPE: if (bit_cnt == 4'd1) state_nxt = type_sr[0] ? ST_ADDR : ST_IDLE;
            ST_ADDR: if (bit_cnt == 4'd7) state_nxt = (type_sr == TYPE_WR) ? ST_DATA : ST_EXEC;
            ST_DATA: if (bit_cnt == 4'd15) state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        l0_hit = 1'b0;
        l1_hit = 1'b0;
        exec   = 1'b0;
        case (state)
            ST_TYPE: if (bit_cnt == 4'd1) begin
                l0_hit = ({type_sr[0], dtc_trig} == TYPE_L0);
                l1_hit = ({type_sr[0], dtc_trig} == TYPE_L1);
            end
            ST_EXEC: exec = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge rdoclk or posedge reset) begin
        if (reset) begin
            bit_cnt <= '0;
            type_sr <= '0;
            addr_sr <= '0;
            data_sr <= '0;
        end else begin
            case (state)
                ST_IDLE: bit_cnt <= '0;
                ST_TYPE: begin
                    type_sr <= {type_sr[0], dtc_trig};
                    bit_cnt <= (bit_cnt == 4'd1) ? 4'd0 : bit_cnt + 4'd1;
                end
                ST_ADDR: begin
                    addr_sr <= {addr_sr[6:0], dtc_trig};
                    bit_cnt <= (bit_cnt == 4'd7) ? 4'd0 : bit_cnt + 4'd1;
                end
                ST_DATA: begin
                    data_sr <= {data_sr[14:0], dtc_trig};
                    bit_cnt <= bit_cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

    // Strobes go low at the decode edge; counters follow one edge later.
    always_ff @(posedge rdoclk or posedge reset) begin
        if (reset) begin
            trig_l0n <= 1'b1;
            trig_l1n <= 1'b1;
            l1_sup   <= 1'b0;
            l0cnt    <= '0;
            l1cnt    <= '0;
        end else begin
            trig_l0n <= ~l0_hit;
            trig_l1n <= ~l1_hit;
            l1_sup   <= l1_hit & fee_flag;
            if (!trig_l0n) l0cnt <= l0cnt + 16'd1;
            if (!trig_l1n) l1cnt <= l1cnt + 16'd1;
        end
    end

    always_comb begin
        rd_val  = '0;
        addr_ok = 1'b1;
        addr_ro = 1'b1;
        case (addr_sr)
            ADDR_VERSION: rd_val = FEEFMVer;
            ADDR_CTRL:    begin rd_val = ctrl;    addr_ro = 1'b0; end
            ADDR_L0CNT:   rd_val = l0cnt;
            ADDR_L1CNT:   rd_val = l1cnt;
            ADDR_SCRATCH: begin rd_val = scratch; addr_ro = 1'b0; end
            ADDR_STATUS:  rd_val = {14'b0, d_busy, fee_flag};
            ADDR_DROPCNT: rd_val = dropcnt;
            default:      addr_ok = 1'b0;
        endcase
    end

    assign is_write = (type_sr == TYPE_WR);
    // A command finishing while a reply is still on the wire is dropped entirely.
    assign exec_ok  = exec & ~r_busy;

    always_comb begin
        rep_err = 1'b0;
        rep_dat = rd_val;
        if (!addr_ok) begin
            rep_err = 1'b1;
            rep_dat = '0;
        end else if (is_write) begin
            rep_err = addr_ro;
            rep_dat = data_sr;
        end
    end

    always_ff @(posedge rdoclk or posedge reset) begin
        if (reset) begin
            ctrl    <= {15'b0, LGSEN_Init};
            scratch <= '0;
        end else if (exec_ok && is_write) begin
            if (addr_sr == ADDR_CTRL)    ctrl    <= data_sr;
            if (addr_sr == ADDR_SCRATCH) scratch <= data_sr;
        end
    end

    assign r_frame = build_reply(rep_err, rep_dat);

    dtc_ser_tx #(.W(REPLY_LEN), .CW(R_CW)) u_reply_tx (
        .clk_sys (rdoclk),
        .rst     (reset),
        .load    (exec_ok),
        .data    (r_frame),
        .len     (R_CW'(REPLY_LEN)),
        .ser     (dtc_return),
        .busy    (r_busy),
        .ready   (unused_r_ready)
    );

    // Acceptance is evaluated in the strobe cycle, where l1cnt still holds the old value.
    assign l1_acc      = ~trig_l1n & ~l1_sup;
    assign evcnt_new   = l1cnt[11:0] + 12'd1;
    assign launch_pend = pend_vld & d_ready;
    assign d_load      = launch_pend | (l1_acc & d_ready & ~pend_vld);
    assign d_lg        = launch_pend ? pend_lg : ctrl[0];
    assign d_frame     = build_event(launch_pend ? pend_ev : evcnt_new, d_lg);
    assign d_len       = d_lg ? EVT_BITS_HI : EVT_BITS_LO;

    always_ff @(posedge rdoclk or posedge reset) begin
        if (reset) begin
            pend_vld <= 1'b0;
            pend_lg  <= 1'b0;
            pend_ev  <= '0;
            dropcnt  <= '0;
        end else if (l1_acc && (!d_ready || pend_vld)) begin
            if (!pend_vld || launch_pend) begin
                pend_vld <= 1'b1;
                pend_ev  <= evcnt_new;
                pend_lg  <= ctrl[0];
            end else begin
                dropcnt <= dropcnt + 16'd1;
            end
        end else if (launch_pend) begin
            pend_vld <= 1'b0;
        end
    end

    dtc_ser_tx #(.W(EVT_LEN), .CW(E_CW)) u_data_tx (
        .clk_sys (rdoclk),
        .rst     (reset),
        .load    (d_load),
        .data    (d_frame),
        .len     (d_len),
        .ser     (dtc_data),
        .busy    (d_busy),
        .ready   (d_ready)
    );

endmodule

// File: tb/tb_dtc_slave_top.sv
// Scoreboard bench for dtc_slave_top: stimulus queues expected replies, event frames and strobes; monitors compare.
module tb_dtc_slave_top;

`ifdef DTC_SLAVE_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int RB = 17 + PB;

    logic rdoclk = 1'b0, dtc_clk = 1'b0, reset = 1'b1, dtc_trig = 1'b0, fee_flag = 1'b0;
    logic dtc_data, dtc_return, trig_l0n, trig_l1n;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct { logic err; logic [15:0] data; int start; } rep_t;
    typedef struct { logic [15:0] hdr; int nw; int start; } evt_t;

    rep_t rep_q[$];
    evt_t evt_q[$];
    int   l0_q[$];
    int   l1_q[$];

    dtc_slave_top #(.LGSEN_Init(1'b1), .FEEFMVer(16'h5043)) dut (
        .rdoclk     (rdoclk),
        .reset      (reset),
        .dtc_clk    (dtc_clk),
        .dtc_trig   (dtc_trig),
        .dtc_data   (dtc_data),
        .dtc_return (dtc_return),
        .trig_l0n   (trig_l0n),
        .trig_l1n   (trig_l1n),
        .fee_flag   (fee_flag)
    );

    always #5 rdoclk  = ~rdoclk;
    always #5 dtc_clk = ~dtc_clk;
    always @(posedge rdoclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input logic [26:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge rdoclk);
            dtc_trig = bits[i];
        end
    endtask

    task automatic release_line();
        @(negedge rdoclk);
        dtc_trig = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge rdoclk);
    endtask

    task automatic cmd(input logic [26:0] bits, input int n, input bit exp, input logic err, input logic [15:0] d);
        rep_t e;
        drive(bits, n);
        if (exp) begin
            e.err = err; e.data = d; e.start = cyc + 2;
            rep_q.push_back(e);
        end
        release_line();
    endtask

    task automatic rd(input logic [7:0] a, input bit exp, input logic err, input logic [15:0] d);
        cmd({16'h0, 3'b111, a}, 11, exp, err, d);
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] v, input logic err, input logic [15:0] d);
        cmd({3'b110, a, v}, 27, 1'b1, err, d);
    endtask

    task automatic send_l0();
        drive(27'b100, 3);
        l0_q.push_back(cyc + 1);
        release_line();
    endtask

    task automatic send_l1(input bit fr, input logic [15:0] hdr, input int nw, input bit chk_start);
        evt_t e;
        drive(27'b101, 3);
        l1_q.push_back(cyc + 1);
        if (fr) begin
            e.hdr = hdr; e.nw = nw; e.start = chk_start ? cyc + 2 : -1;
            evt_q.push_back(e);
        end
        release_line();
    endtask

    task automatic read_word(output logic [15:0] w);
        w = '0;
        for (int i = 0; i < 16; i++) begin
            @(negedge rdoclk);
            w = {w[14:0], dtc_data};
        end
    endtask

    initial begin : reply_mon
        logic [RB-1:0] sh;
        rep_t e;
        int st;
        forever begin
            @(negedge rdoclk);
            if (dtc_return === 1'b1) begin
                st = cyc;
                sh = '0;
                for (int i = 0; i < RB; i++) begin
                    @(negedge rdoclk);
                    sh = {sh[RB-2:0], dtc_return};
                end
                if (rep_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL reply_unexpected: got 0x%0h expected no reply", sh);
                end else begin
                    e = rep_q.pop_front();
                    chk("reply_err", 32'(sh[RB-1]), 32'(e.err));
                    chk("reply_data", 32'(sh[RB-2 -: 16]), 32'(e.data));
                    chk("reply_start_cycle", st, e.start);
`ifdef DTC_SLAVE_PARITY_EN
                    chk("reply_parity", 32'(sh[0]), 32'(^sh[RB-1:1]));
`endif
                end
            end
        end
    end

    initial begin : event_mon
        logic [15:0] w;
        logic [7:0]  kb;
        logic        par;
        evt_t        e;
        int          st;
        forever begin
            @(negedge rdoclk);
            if (dtc_data === 1'b1) begin
                st = cyc;
                read_word(w);
                par = ^w;
                if (evt_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL evt_unexpected: got header 0x%0h expected no frame", w);
                end else begin
                    e = evt_q.pop_front();
                    chk("evt_header", 32'(w), 32'(e.hdr));
                    if (e.start >= 0) chk("evt_start_cycle", st, e.start);
                    for (int k = 0; k < e.nw; k++) begin
                        read_word(w);
                        par = par ^ (^w);
                        kb = 8'(k);
                        chk("evt_word", 32'(w), 32'({e.hdr[7:0], kb}));
                    end
`ifdef DTC_SLAVE_PARITY_EN
                    @(negedge rdoclk);
                    chk("evt_parity", 32'(dtc_data), 32'(par));
`endif
                end
            end
        end
    end

    initial begin : strobe_mon
        int x;
        forever begin
            @(negedge rdoclk);
            if (trig_l0n === 1'b0) begin
                if (l0_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL l0_unexpected: strobe at cycle %0d expected none", cyc);
                end else begin
                    x = l0_q.pop_front();
                    chk("l0_strobe_cycle", cyc, x);
                end
            end
            if (trig_l1n === 1'b0) begin
                if (l1_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL l1_unexpected: strobe at cycle %0d expected none", cyc);
                end else begin
                    x = l1_q.pop_front();
                    chk("l1_strobe_cycle", cyc, x);
                end
            end
        end
    end

    initial begin : stim
        reset = 1'b1;
        #500;
        reset = 1'b0;
        @(negedge rdoclk);
        chk("idle_dtc_data", 32'(dtc_data), 32'd0);
        chk("idle_dtc_return", 32'(dtc_return), 32'd0);
        chk("idle_trig_l0n", 32'(trig_l0n), 32'd1);
        chk("idle_trig_l1n", 32'(trig_l1n), 32'd1);
        gap(3);

        rd(8'h01, 1'b1, 1'b0, 16'h0001);  gap(22);
        rd(8'h00, 1'b1, 1'b0, 16'h5043);  gap(22);
        wr(8'h04, 16'hBEEF, 1'b0, 16'hBEEF); gap(22);
        rd(8'h04, 1'b1, 1'b0, 16'hBEEF);  gap(22);

        send_l0();                        gap(4);
        rd(8'h02, 1'b1, 1'b0, 16'h0001);  gap(22);

        send_l1(1'b1, 16'hA001, 8, 1'b1); gap(160);
        wr(8'h01, 16'h0000, 1'b0, 16'h0000); gap(22);
        send_l1(1'b1, 16'hA002, 4, 1'b1); gap(95);

        send_l1(1'b1, 16'hA003, 4, 1'b1);
        send_l1(1'b1, 16'hA004, 4, 1'b0);
        send_l1(1'b0, 16'h0000, 0, 1'b0);
        gap(190);
        rd(8'h06, 1'b1, 1'b0, 16'h0001);  gap(22);
        rd(8'h03, 1'b1, 1'b0, 16'h0005);  gap(22);

        fee_flag = 1'b1;
        send_l1(1'b0, 16'h0000, 0, 1'b0); gap(10);
        rd(8'h05, 1'b1, 1'b0, 16'h0001);  gap(22);
        rd(8'h03, 1'b1, 1'b0, 16'h0006);  gap(22);
        fee_flag = 1'b0;

        rd(8'h07, 1'b1, 1'b1, 16'h0000);  gap(22);
        wr(8'h00, 16'h1234, 1'b1, 16'h1234); gap(22);
        rd(8'h00, 1'b1, 1'b0, 16'h5043);  gap(22);
        wr(8'h01, 16'hFFFE, 1'b0, 16'hFFFE); gap(22);
        rd(8'h01, 1'b1, 1'b0, 16'hFFFE);  gap(22);

        rd(8'h04, 1'b1, 1'b0, 16'hBEEF);
        rd(8'h01, 1'b0, 1'b0, 16'h0000);
        gap(40);

        chk("reply_queue_drained", rep_q.size(), 0);
        chk("event_queue_drained", evt_q.size(), 0);
        chk("l0_queue_drained", l0_q.size(), 0);
        chk("l1_queue_drained", l1_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
